// File: rtl/fir_da_sequencer_pkg.sv
// ============================================================================
// Module   : fir_ctrl_pkg (package)
// Purpose  : Shared types and default widths for the FIR distributed-
//            arithmetic sequencer: the controller state encoding, default
//            bus widths and the bit-index width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fir_ctrl_pkg;

    localparam int DEF_DATA_W      = 16;
    localparam int DEF_BIT_CYCLES  = 16;
    localparam int DEF_CIN_W       = 20;
    localparam int DEF_CADDR_W     = 11;
    localparam int DEF_WDOG_CYCLES = 64;

    // Width of a counter indexing 0..n-1; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int BIT_IDX_W = idx_width(DEF_BIT_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_SHIFT     = 3'd2,
        ST_CLR       = 3'd3,
        ST_RUN       = 3'd4,
        ST_WAIT_DONE = 3'd5,
        ST_OUT       = 3'd6
    } state_t;

endpackage : fir_ctrl_pkg

`default_nettype wire

// File: rtl/fir_da_sequencer_if.sv
// ============================================================================
// Module   : fir_da_sequencer_if (interface)
// Purpose  : Bundles the sample, coefficient-load and DA-engine signals of
//            the FIR DA sequencer.
// Ports    : slave  - sequencer side (consumes valid_in/din, cload_req/cin/
//                     caddr, da_done; drives everything else)
//            master - environment side (host, delay line and DA engine)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fir_da_sequencer_if #(
    parameter int DATA_W     = fir_ctrl_pkg::DEF_DATA_W,
    parameter int BIT_CYCLES = fir_ctrl_pkg::DEF_BIT_CYCLES,
    parameter int CIN_W      = fir_ctrl_pkg::DEF_CIN_W,
    parameter int CADDR_W    = fir_ctrl_pkg::DEF_CADDR_W
);
    import fir_ctrl_pkg::*;

    localparam int IDX_W = idx_width(BIT_CYCLES);

    // Sample input
    logic                valid_in;
    logic [DATA_W-1:0]   din;
    logic                ready_in;
    // Host coefficient loader
    logic                cload_req;
    logic [CIN_W-1:0]    cin;
    logic [CADDR_W-1:0]  caddr;
    logic                cload_ack;
    // Delay line
    logic                fifo_shift;
    logic [DATA_W-1:0]   fifo_din;
    // DA engine
    logic                da_reset;
    logic                da_start;
    logic [IDX_W-1:0]    da_bit_idx;
    logic                da_cload;
    logic [CIN_W-1:0]    da_cin;
    logic [CADDR_W-1:0]  da_caddr;
    logic                da_done;
    // Status
    logic                valid_out;
    logic                busy;
    logic                overrun;
    logic                fault;

    modport slave (
        input  valid_in, din, cload_req, cin, caddr, da_done,
        output ready_in, cload_ack, fifo_shift, fifo_din, da_reset, da_start,
               da_bit_idx, da_cload, da_cin, da_caddr, valid_out, busy,
               overrun, fault
    );

    modport master (
        output valid_in, din, cload_req, cin, caddr, da_done,
        input  ready_in, cload_ack, fifo_shift, fifo_din, da_reset, da_start,
               da_bit_idx, da_cload, da_cin, da_caddr, valid_out, busy,
               overrun, fault
    );

endinterface : fir_da_sequencer_if

`default_nettype wire

// File: rtl/fir_da_sequencer_seq_counter.sv
// ============================================================================
// Module   : seq_counter
// Purpose  : Loadable up-counter with terminal-count flag.
// Ports    : clk, resetn      - clock, synchronous active-low reset
//            clr_i            - load load_val_i (priority over en_i)
//            en_i             - increment enable
//            load_val_i       - value loaded on clr_i
//            count_o          - registered count
//            tc_o             - count_o equals TERMINAL
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_counter #(
    parameter int WIDTH    = 4,
    parameter int TERMINAL = 15
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= load_val_i;
        end else if (en_i) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == WIDTH'(TERMINAL));

endmodule : seq_counter

`default_nettype wire

// File: rtl/fir_da_sequencer.sv
// ============================================================================
// Module   : fir_da_sequencer
// Purpose  : Sequences one FIR output per input sample: shift the delay
//            line, clear the DA accumulator, run BIT_CYCLES bit-serial
//            steps, wait for da_done and flag valid_out. Host coefficient
//            writes to the DA memory take priority over samples.
// Ports    : clk    - system clock, rising edge
//            resetn - synchronous active-low reset
//            bus    - fir_da_sequencer_if.slave (sample, coefficient-load,
//                     delay-line, DA-engine and status signals)
// Options  : DA_WATCHDOG_EN - when defined, WAIT_DONE is bounded by
//            WDOG_CYCLES; expiry sets sticky fault and returns to IDLE.
//            When undefined, fault is tied low and WAIT_DONE is unbounded.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_da_sequencer #(
    parameter int DATA_W      = fir_ctrl_pkg::DEF_DATA_W,
    parameter int BIT_CYCLES  = fir_ctrl_pkg::DEF_BIT_CYCLES,
    parameter int CIN_W       = fir_ctrl_pkg::DEF_CIN_W,
    parameter int CADDR_W     = fir_ctrl_pkg::DEF_CADDR_W
`ifdef DA_WATCHDOG_EN
    ,
    parameter int WDOG_CYCLES = fir_ctrl_pkg::DEF_WDOG_CYCLES
`endif
) (
    input  logic               clk,
    input  logic               resetn,
    fir_da_sequencer_if.slave  bus
);
    import fir_ctrl_pkg::*;

    localparam int IDX_W = idx_width(BIT_CYCLES);

    state_t               state_q, state_d;
    logic [DATA_W-1:0]    fifo_din_q, fifo_din_d;
    logic [CIN_W-1:0]     da_cin_q, da_cin_d;
    logic [CADDR_W-1:0]   da_caddr_q, da_caddr_d;
    logic                 overrun_q, overrun_d;
    logic                 fifo_shift_q;
    logic                 da_reset_q;
    logic                 da_start_q;
    logic                 da_cload_q;
    logic                 cload_ack_q;
    logic                 valid_out_q;
    logic                 busy_q;
    logic                 idle_q;
    logic                 ready_w;
    logic                 bit_clr_w;
    logic                 bit_tc_w;
    logic [IDX_W-1:0]     bit_idx_w;

    // idle_q is the registered "state is IDLE" flag; only the coefficient
    // priority term is applied combinationally so that a request arriving
    // in the same cycle as a sample blocks that sample.
    assign ready_w = idle_q & ~bus.cload_req;

    // Bit counter holds 0 everywhere except while staying in RUN, so its
    // register doubles as the da_bit_idx output.
    assign bit_clr_w = !((state_q == ST_RUN) && (state_d == ST_RUN));

    seq_counter #(
        .WIDTH    (IDX_W),
        .TERMINAL (BIT_CYCLES - 1)
    ) u_bit_cnt (
        .clk        (clk),
        .resetn     (resetn),
        .clr_i      (bit_clr_w),
        .en_i       (1'b1),
        .load_val_i ('0),
        .count_o    (bit_idx_w),
        .tc_o       (bit_tc_w)
    );

`ifdef DA_WATCHDOG_EN
    localparam int WDOG_W = idx_width(WDOG_CYCLES);

    logic               fault_q, fault_d;
    logic               wdog_clr_w;
    logic               wdog_tc_w;
    logic [WDOG_W-1:0]  wdog_cnt_w;

    // Counts WAIT_DONE cycles; terminal count marks the last allowed one.
    assign wdog_clr_w = !((state_q == ST_WAIT_DONE) && (state_d == ST_WAIT_DONE));

    seq_counter #(
        .WIDTH    (WDOG_W),
        .TERMINAL (WDOG_CYCLES - 1)
    ) u_wdog_cnt (
        .clk        (clk),
        .resetn     (resetn),
        .clr_i      (wdog_clr_w),
        .en_i       (1'b1),
        .load_val_i ('0),
        .count_o    (wdog_cnt_w),
        .tc_o       (wdog_tc_w)
    );

    assign bus.fault = fault_q;
`else
    assign bus.fault = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        fifo_din_d = fifo_din_q;
        da_cin_d   = da_cin_q;
        da_caddr_d = da_caddr_q;
        overrun_d  = overrun_q | (bus.valid_in & ~ready_w);
`ifdef DA_WATCHDOG_EN
        fault_d    = fault_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.cload_req) begin
                    state_d    = ST_LOAD;
                    da_cin_d   = bus.cin;
                    da_caddr_d = bus.caddr;
                end else if (bus.valid_in && ready_w) begin
                    state_d    = ST_SHIFT;
                    fifo_din_d = bus.din;
                end
            end
            ST_LOAD:  state_d = ST_IDLE;
            ST_SHIFT: state_d = ST_CLR;
            ST_CLR:   state_d = ST_RUN;
            ST_RUN: begin
                if (bit_tc_w) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (bus.da_done) begin
                    state_d = ST_OUT;
`ifdef DA_WATCHDOG_EN
                end else if (wdog_tc_w) begin
                    state_d = ST_IDLE;
                    fault_d = 1'b1;
`endif
                end
            end
            ST_OUT:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the next state and registered, so each one
    // is high exactly in the cycle its state is current.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            fifo_din_q   <= '0;
            da_cin_q     <= '0;
            da_caddr_q   <= '0;
            overrun_q    <= 1'b0;
            fifo_shift_q <= 1'b0;
            da_reset_q   <= 1'b0;
            da_start_q   <= 1'b0;
            da_cload_q   <= 1'b0;
            cload_ack_q  <= 1'b0;
            valid_out_q  <= 1'b0;
            busy_q       <= 1'b0;
            idle_q       <= 1'b0;
`ifdef DA_WATCHDOG_EN
            fault_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            fifo_din_q   <= fifo_din_d;
            da_cin_q     <= da_cin_d;
            da_caddr_q   <= da_caddr_d;
            overrun_q    <= overrun_d;
            fifo_shift_q <= (state_d == ST_SHIFT);
            da_reset_q   <= (state_d == ST_CLR);
            da_start_q   <= (state_d == ST_RUN);
            da_cload_q   <= (state_d == ST_LOAD);
            cload_ack_q  <= (state_d == ST_LOAD);
            valid_out_q  <= (state_d == ST_OUT);
            busy_q       <= (state_d != ST_IDLE);
            idle_q       <= (state_d == ST_IDLE);
`ifdef DA_WATCHDOG_EN
            fault_q      <= fault_d;
`endif
        end
    end

    assign bus.ready_in   = ready_w;
    assign bus.cload_ack  = cload_ack_q;
    assign bus.fifo_shift = fifo_shift_q;
    assign bus.fifo_din   = fifo_din_q;
    assign bus.da_reset   = da_reset_q;
    assign bus.da_start   = da_start_q;
    assign bus.da_bit_idx = bit_idx_w;
    assign bus.da_cload   = da_cload_q;
    assign bus.da_cin     = da_cin_q;
    assign bus.da_caddr   = da_caddr_q;
    assign bus.valid_out  = valid_out_q;
    assign bus.busy       = busy_q;
    assign bus.overrun    = overrun_q;

endmodule : fir_da_sequencer

`default_nettype wire

// File: tb/tb_fir_da_sequencer.sv
// ============================================================================
// Module   : tb_fir_da_sequencer
// Purpose  : Self-checking bench for fir_da_sequencer: a table of per-cycle
//            stimulus/expected records plus hand-written corner sequences
//            (mid-run reset, collision, unanswered WAIT_DONE).
// Ports    : none
// Options  : DA_WATCHDOG_EN selects the watchdog-expiry expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_da_sequencer;

    logic clk;
    logic resetn;

    fir_da_sequencer_if bus ();

    fir_da_sequencer u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ctl bits: {ready_in, busy, fifo_shift, da_reset, da_start,
    //            da_bit_idx[3:0], da_cload, cload_ack, valid_out, overrun, fault}
    typedef struct {
        string       tag;
        logic        valid_in;
        logic [15:0] din;
        logic        cload_req;
        logic [19:0] cin;
        logic [10:0] caddr;
        logic        da_done;
        logic [13:0] e_ctl;
        logic [15:0] e_fifo;
        logic [19:0] e_cin;
        logic [10:0] e_caddr;
    } vec_t;

    vec_t        tbl[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] m_fifo  = '0;
    logic [19:0] m_cin   = '0;
    logic [10:0] m_caddr = '0;

    function automatic logic [13:0] mk(input logic rdy, input logic bsy,
                                       input logic sh, input logic clr,
                                       input logic st, input logic [3:0] idx,
                                       input logic cl, input logic ack,
                                       input logic vo, input logic ov,
                                       input logic ft);
        return {rdy, bsy, sh, clr, st, idx, cl, ack, vo, ov, ft};
    endfunction

    function automatic logic [13:0] obs_ctl();
        return {bus.ready_in, bus.busy, bus.fifo_shift, bus.da_reset,
                bus.da_start, bus.da_bit_idx, bus.da_cload, bus.cload_ack,
                bus.valid_out, bus.overrun, bus.fault};
    endfunction

    function automatic logic [63:0] obs_data();
        return {17'd0, bus.fifo_din, bus.da_cin, bus.da_caddr};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_row(input string tag, input logic vin,
                           input logic [15:0] d, input logic creq,
                           input logic [19:0] c, input logic [10:0] a,
                           input logic done, input logic [13:0] e);
        vec_t v;
        v.tag = tag; v.valid_in = vin; v.din = d; v.cload_req = creq;
        v.cin = c; v.caddr = a; v.da_done = done; v.e_ctl = e;
        v.e_fifo = m_fifo; v.e_cin = m_cin; v.e_caddr = m_caddr;
        tbl.push_back(v);
    endtask

    // One sample job, cycles 0..20: accept at 0, stray da_done in RUN at 8,
    // real da_done at 19 (first WAIT_DONE cycle), optional dropped sample.
    task automatic add_job(input string tag, input logic [15:0] d,
                           input int drop_at, input logic ovr0);
        for (int c = 0; c <= 20; c++) begin
            logic       ov;
            logic [3:0] idx;
            ov  = ovr0 | ((drop_at >= 0) && (c > drop_at));
            idx = (c >= 3 && c <= 18) ? 4'(c - 3) : 4'd0;
            add_row(tag, (c == 0) || (c == drop_at),
                    (c == 0) ? d : 16'h5555, 1'b0, 20'h0, 11'h0,
                    (c == 19) || (c == 8),
                    mk(c == 0, c != 0, c == 1, c == 2, (c >= 3 && c <= 18),
                       idx, 1'b0, 1'b0, c == 20, ov, 1'b0));
            if (c == 0) m_fifo = d;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.valid_in  = 1'b0;
        bus.din       = '0;
        bus.cload_req = 1'b0;
        bus.cin       = '0;
        bus.caddr     = '0;
        bus.da_done   = 1'b0;
    endtask

    initial begin
        idle_inputs();
        resetn = 1'b0;

        // ---------------- vector table ----------------
        add_job("single", 16'h1234, -1, 1'b0);
        add_row("load", 1'b0, 16'h0, 1'b1, 20'hABCDE, 11'h07F, 1'b0,
                mk(0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0));
        m_cin = 20'hABCDE; m_caddr = 11'h07F;
        add_row("load", 1'b0, 16'h0, 1'b1, 20'hABCDE, 11'h07F, 1'b0,
                mk(0, 1, 0, 0, 0, 4'd0, 1, 1, 0, 0, 0));
        add_row("load", 1'b0, 16'h0, 1'b0, 20'h0, 11'h0, 1'b0,
                mk(1, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0));
        add_job("b2b", 16'hBEEF, 10, 1'b0);

        // ---------------- reset state ----------------
        tick();
        tick();
        #1;
        chk("reset_ctl", 64'(obs_ctl()), 64'h0);
        chk("reset_data", obs_data(), 64'h0);
        resetn = 1'b1;
        tick();

        // ---------------- table run ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            bus.valid_in  = tbl[i].valid_in;
            bus.din       = tbl[i].din;
            bus.cload_req = tbl[i].cload_req;
            bus.cin       = tbl[i].cin;
            bus.caddr     = tbl[i].caddr;
            bus.da_done   = tbl[i].da_done;
            #2;
            chk($sformatf("%s[%0d] ctl", tbl[i].tag, i), 64'(obs_ctl()),
                64'(tbl[i].e_ctl));
            chk($sformatf("%s[%0d] data", tbl[i].tag, i), obs_data(),
                {17'd0, tbl[i].e_fifo, tbl[i].e_cin, tbl[i].e_caddr});
            tick();
        end
        idle_inputs();

        // ---------------- third sample at cycle 21, reset at bit 5 ----------
        bus.valid_in = 1'b1;
        bus.din      = 16'h0F0F;
        #1;
        chk("third_accept", 64'(obs_ctl()),
            64'(mk(1, 0, 0, 0, 0, 4'd0, 0, 0, 0, 1, 0)));
        tick();
        idle_inputs();
        #1;
        chk("third_shift", 64'(obs_ctl()),
            64'(mk(0, 1, 1, 0, 0, 4'd0, 0, 0, 0, 1, 0)));
        chk("third_fifo_din", 64'(bus.fifo_din), 64'h0F0F);
        repeat (7) tick();
        #1;
        chk("third_bit5", 64'(obs_ctl()),
            64'(mk(0, 1, 0, 0, 1, 4'd5, 0, 0, 0, 1, 0)));
        resetn = 1'b0;
        tick();
        tick();
        #1;
        chk("midrun_reset_ctl", 64'(obs_ctl()), 64'h0);
        chk("midrun_reset_data", obs_data(), 64'h0);
        resetn = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            bus.da_done = (k % 3 == 0);
            #1;
            chk($sformatf("post_reset_quiet[%0d]", k),
                {62'd0, bus.valid_out, bus.busy}, 64'h0);
        end
        idle_inputs();

        // ---------------- collision: cload_req with valid_in ----------------
        tick();
        bus.valid_in  = 1'b1;
        bus.din       = 16'hAAAA;
        bus.cload_req = 1'b1;
        bus.cin       = 20'h12345;
        bus.caddr     = 11'h100;
        #1;
        chk("coll_req", 64'(obs_ctl()),
            64'(mk(0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0)));
        tick();
        bus.valid_in = 1'b0;
        #1;
        chk("coll_load", 64'(obs_ctl()),
            64'(mk(0, 1, 0, 0, 0, 4'd0, 1, 1, 0, 1, 0)));
        chk("coll_data", obs_data(), {17'd0, 16'h0000, 20'h12345, 11'h100});
        tick();
        idle_inputs();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("coll_after[%0d]", k), 64'(obs_ctl()),
                64'(mk(1, 0, 0, 0, 0, 4'd0, 0, 0, 0, 1, 0)));
            tick();
        end

        // ---------------- unanswered WAIT_DONE ----------------
        bus.valid_in = 1'b1;
        bus.din      = 16'h7777;
        tick();
        idle_inputs();
        repeat (18) tick();
        #1;
        chk("wait_enter", 64'(obs_ctl()),
            64'(mk(0, 1, 0, 0, 0, 4'd0, 0, 0, 0, 1, 0)));
`ifdef DA_WATCHDOG_EN
        for (int k = 1; k < 64; k++) begin
            tick();
            chk($sformatf("wdog_wait[%0d]", k),
                {61'd0, bus.busy, bus.valid_out, bus.fault}, 64'h4);
        end
        tick();
        chk("wdog_expired", 64'(obs_ctl()),
            64'(mk(1, 0, 0, 0, 0, 4'd0, 0, 0, 0, 1, 1)));
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("wdog_after[%0d]", k),
                {61'd0, bus.busy, bus.valid_out, bus.fault}, 64'h1);
        end
`else
        for (int k = 0; k < 100; k++) begin
            tick();
            chk($sformatf("wait_forever[%0d]", k),
                {61'd0, bus.busy, bus.valid_out, bus.fault}, 64'h4);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fir_da_sequencer

`default_nettype wire

// File: doc/fir_da_sequencer.md
Name: fir_da_sequencer

Overview:
Single-clock controller that sequences the bit-serial distributed-arithmetic (DA) engine and its sample delay-line FIFO for one FIR output per input sample. It arbitrates the DA coefficient-memory write port between a host coefficient loader and the sample pipeline. It accepts a sample, shifts it into the delay line, clears and runs the DA for a fixed number of bit cycles, waits for completion and flags a valid output. It replaces ad-hoc multi-clock sequencing with one deterministic FSM.

Parameters:
DATA_W, 16, sample width
BIT_CYCLES, 16, DA iterations per output (one per sample bit)
CIN_W, 20, coefficient word width
CADDR_W, 11, coefficient address width
WDOG_CYCLES, 64, max cycles in WAIT_DONE before fault (used only with DA_WATCHDOG_EN)

Ports:
clk  in  1  single system clock, rising edge
resetn  in  1  reset; synchronous, active-low
valid_in  in  1  sample strobe, one cycle per sample
din  in  DATA_W  sample data
ready_in  out  1  high when a valid_in this cycle is accepted
cload_req  in  1  host coefficient-write request, held until cload_ack
cin  in  CIN_W  coefficient data
caddr  in  CADDR_W  coefficient address
cload_ack  out  1  one-cycle write-done pulse
fifo_shift  out  1  one-cycle delay-line shift enable
fifo_din  out  DATA_W  sample registered for the delay line
da_reset  out  1  one-cycle accumulator clear
da_start  out  1  high for each DA bit cycle
da_bit_idx  out  clog2(BIT_CYCLES)  current bit index, 0 first
da_cload  out  1  coefficient write strobe to DA
da_cin  out  CIN_W  registered coefficient data
da_caddr  out  CADDR_W  registered coefficient address
da_done  in  1  DA completion pulse
valid_out  out  1  one-cycle pulse: DA result valid this cycle
busy  out  1  high in any state except IDLE
overrun  out  1  sticky: valid_in dropped while not ready
fault  out  1  sticky: watchdog expired (tied 0 without DA_WATCHDOG_EN)

Behaviour:
- All outputs registered. Reset (resetn=0 at a rising edge): state=IDLE, every output 0, counters 0, sticky flags cleared. Reset mid-operation aborts immediately; no valid_out or cload_ack is emitted for the aborted job.
- ready_in = (state==IDLE) && !cload_req. Coefficient load has priority over samples.
- States: IDLE, LOAD, SHIFT, CLR, RUN, WAIT_DONE, OUT.
- IDLE: cload_req -> LOAD; else valid_in -> capture din into fifo_din, go to SHIFT; else stay.
- LOAD (1 cycle): da_cload=1 with captured cin/caddr; cload_ack=1 in the same cycle; -> IDLE. The host must drop cload_req the cycle after the ack, otherwise a second write is issued.
- SHIFT (1 cycle): fifo_shift=1 -> CLR.
- CLR (1 cycle): da_reset=1 -> RUN.
- RUN: da_start=1 for exactly BIT_CYCLES cycles; da_bit_idx counts 0..BIT_CYCLES-1 and is 0 outside RUN; -> WAIT_DONE after the last bit.
- WAIT_DONE: on da_done -> OUT. A da_done seen in any other state is ignored.
- OUT (1 cycle): valid_out=1 -> IDLE.
- Latency, with da_done returned on the first WAIT_DONE cycle: accept at cycle 0, valid_out at cycle BIT_CYCLES+4 (20 with defaults). Minimum sample spacing is BIT_CYCLES+5 cycles.
- valid_in while ready_in=0 (busy, or cload_req pending): sample dropped, overrun set. overrun clears only on reset.
- valid_in and cload_req in the same IDLE cycle: LOAD wins, sample dropped, overrun set.

Optional Feature:
DA_WATCHDOG_EN
- Defined: a counter runs in WAIT_DONE. If it reaches WDOG_CYCLES with no da_done, set fault (sticky), go to IDLE, and emit no valid_out.
- Undefined: WAIT_DONE waits indefinitely; fault is constant 0; no counter logic.

Decomposition:
- Package fir_ctrl_pkg: state enum (7 states, binary encoding), default widths (DATA_W, CIN_W, CADDR_W, BIT_CYCLES), derived BIT_IDX_W = clog2(BIT_CYCLES).
- One sub-module, seq_counter: loadable up-counter with terminal-count flag. Instantiated for the bit counter and, when enabled, the watchdog.

Test Plan:
- Reset: resetn=0 for 2 cycles mid-RUN (bit 5) -> next cycle all outputs 0, state IDLE, no valid_out afterwards.
- Single sample: din=16'h1234, valid_in at cycle 0, da_done returned 1 cycle into WAIT_DONE -> fifo_din=16'h1234 with fifo_shift at cycle 1, da_reset at cycle 2, da_start high cycles 3..18 with da_bit_idx 0..15, valid_out at cycle 20.
- Coefficient load: cload_req with cin=20'hABCDE, caddr=11'h07F in IDLE -> da_cload and cload_ack the following cycle, carrying those values; ready_in=0 while cload_req is high.
- Collision: valid_in and cload_req in the same IDLE cycle -> LOAD executes, no fifo_shift, overrun=1 and stays 1.
- Back-to-back: second valid_in 10 cycles after the first -> dropped, overrun=1; third valid_in at cycle 21 -> accepted normally.
- DA_WATCHDOG_EN defined, WDOG_CYCLES=64, da_done never asserted -> fault=1 after 64 WAIT_DONE cycles, state IDLE, no valid_out; without the macro -> busy stays 1 indefinitely.
